// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared constants and helpers for the handshake byte packer
//
// Contents:
//   HS_DATA_W     width of one handshake beat (byte lane)
//   HS_MAX_LANES  largest supported lane count
//   clog2(n)      ceil(log2(n)), never less than 1 so counters keep a bit
//   therm_mask(n) n ones from bit 0
package hs_pkg;

    localparam int HS_DATA_W    = 8;
    localparam int HS_MAX_LANES = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [HS_MAX_LANES-1:0] therm_mask(input int n);
        logic [HS_MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < HS_MAX_LANES; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/hs_out_reg.sv
// rtl/hs_out_reg.sv - registered output slice of the byte packer
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   load_i         a word closes this cycle (closing beat accepted)
//   word_i/keep_i/last_i  word to capture on load_i
//   ready_post_i   downstream ready
//   valid_post_o, data_o, keep_o, last_o  registered output word
//   ready_pre_o    upstream ready: output slot free or draining this cycle
module hs_out_reg
    import hs_pkg::*;
#(
    parameter int DATA_W = HS_DATA_W,
    parameter int LANES  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load_i,
    input  logic [DATA_W*LANES-1:0] word_i,
    input  logic [LANES-1:0]        keep_i,
    input  logic                    last_i,
    input  logic                    ready_post_i,
    output logic                    valid_post_o,
    output logic [DATA_W*LANES-1:0] data_o,
    output logic [LANES-1:0]        keep_o,
    output logic                    last_o,
    output logic                    ready_pre_o
);

    // Only combinational path from downstream to upstream.
    assign ready_pre_o = !valid_post_o || ready_post_i;

    // A load wins over the drain so back-to-back words have no bubble;
    // payload is only written on load so it stays stable while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_post_o <= 1'b0;
            data_o       <= '0;
            keep_o       <= '0;
            last_o       <= 1'b0;
        end else if (load_i) begin
            valid_post_o <= 1'b1;
            data_o       <= word_i;
            keep_o       <= keep_i;
            last_o       <= last_i;
        end else if (valid_post_o && ready_post_i) begin
            valid_post_o <= 1'b0;
        end
    end

endmodule

// File: rtl/handshake_byte_packer.sv
// rtl/handshake_byte_packer.sv - packs DATA_W-bit beats into LANES-lane words
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   valid_pre_i, ready_pre_o     upstream beat handshake
//   data_i, last_i               beat payload, packet-end marker
//   valid_post_o, ready_post_i   downstream word handshake
//   data_o                       packed word, lane 0 = first beat
//   keep_o                       thermometer lane-valid mask
//   last_o                       word was closed by last_i
module handshake_byte_packer
    import hs_pkg::*;
#(
    parameter int DATA_W = HS_DATA_W,
    parameter int LANES  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    valid_pre_i,
    output logic                    ready_pre_o,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    last_i,
    output logic                    valid_post_o,
    input  logic                    ready_post_i,
    output logic [DATA_W*LANES-1:0] data_o,
    output logic [LANES-1:0]        keep_o,
    output logic                    last_o
);

    localparam int              CNT_W     = clog2(LANES);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    logic [CNT_W-1:0]           cnt;
    logic [DATA_W*(LANES-1)-1:0] acc;
    logic [LANES-2:0]           acc_keep;

    logic                       in_fire;
    logic                       close;
    logic                       load;
    logic [DATA_W*LANES-1:0]    word;
    logic [LANES-1:0]           word_keep;

    assign in_fire   = valid_pre_i && ready_pre_o;
    assign close     = (cnt == LAST_LANE) || last_i;
    assign load      = in_fire && close;
    assign word_keep = LANES'(therm_mask(int'(cnt) + 1));

    // Lanes already filled come from the accumulator, the current lane takes
    // the incoming beat, and everything above is forced to zero.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        if (g < LANES - 1) begin : g_acc
            assign word[g*DATA_W +: DATA_W] =
                acc_keep[g]             ? acc[g*DATA_W +: DATA_W] :
                (cnt == CNT_W'(g))      ? data_i                  : '0;
        end else begin : g_top
            assign word[g*DATA_W +: DATA_W] = (cnt == CNT_W'(g)) ? data_i : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            acc      <= '0;
            acc_keep <= '0;
        end else if (in_fire) begin
            if (close) begin
                cnt      <= '0;
                acc      <= '0;
                acc_keep <= '0;
            end else begin
                for (int i = 0; i < LANES - 1; i++) begin
                    if (cnt == CNT_W'(i)) begin
                        acc[i*DATA_W +: DATA_W] <= data_i;
                        acc_keep[i]             <= 1'b1;
                    end
                end
                cnt <= cnt + 1'b1;
            end
        end
    end

    hs_out_reg #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_out_reg (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_i       (load),
        .word_i       (word),
        .keep_i       (word_keep),
        .last_i       (last_i),
        .ready_post_i (ready_post_i),
        .valid_post_o (valid_post_o),
        .data_o       (data_o),
        .keep_o       (keep_o),
        .last_o       (last_o),
        .ready_pre_o  (ready_pre_o)
    );

endmodule

// File: doc/handshake_byte_packer.md
Name: handshake_byte_packer

Overview:
- Valid/ready width-conversion stage that sits directly downstream of the 8-bit forward-registered handshake stage.
- Accumulates consecutive 8-bit beats into a LANES x 8-bit word and presents it downstream with a per-lane keep mask.
- An input last marker closes a partial word early.
- Output is registered; ready_pre_o has a single combinational path from ready_post_i, with the same form as the upstream stage.

Parameters:
- DATA_W, 8, width of one input beat (byte lane).
- LANES, 4, beats per output word; legal range 2..16.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- valid_pre_i  input  1  upstream beat valid.
- ready_pre_o  output  1  beat accepted when valid_pre_i && ready_pre_o.
- data_i  input  DATA_W  upstream beat data.
- last_i  input  1  beat is the final one of a packet; closes the current word.
- valid_post_o  output  1  output word valid (registered).
- ready_post_i  input  1  downstream ready.
- data_o  output  DATA_W*LANES  packed word; lane 0 in bits [DATA_W-1:0] holds the first beat.
- keep_o  output  LANES  lane-valid mask, thermometer from lane 0.
- last_o  output  1  word closed by last_i.

Behaviour:
- Reset (asynchronous, reset_n low): valid_post_o=0, data_o=0, keep_o=0, last_o=0, lane counter=0, accumulator=0.
  - Reset mid-word discards the partial word. No output is produced for it.
- Handshake:
  - ready_pre_o = !valid_post_o || ready_post_i.
  - ready_pre_o never depends on valid_pre_i or last_i.
  - in_fire = valid_pre_i && ready_pre_o.
  - out_fire = valid_post_o && ready_post_i.
- State:
  - Lane counter cnt, range 0..LANES-1, width clog2(LANES).
  - Accumulator acc holds lanes 0..LANES-2, plus acc_keep.
- On in_fire with close = (cnt==LANES-1) || last_i:
  - close=0: write data_i into acc lane cnt, set acc_keep[cnt], cnt++.
  - close=1: load output register with data_o = acc lanes 0..cnt-1 plus data_i in lane cnt, and zeros above.
    - keep_o = thermometer of cnt+1 ones.
    - last_o = last_i.
    - valid_post_o = 1.
    - Clear acc, acc_keep and cnt.
- On out_fire without a close in the same cycle: valid_post_o=0. data_o, keep_o and last_o hold their values.
- Simultaneous out_fire and close: the new word replaces the old one. valid_post_o stays 1 with no bubble.
- Stall: valid_post_o=1 and ready_post_i=0 forces ready_pre_o=0.
  - acc and cnt hold.
  - data_o, keep_o and last_o remain stable until out_fire (AXI-style stability).
- Latency: the closing beat appears on data_o one cycle after its in_fire.
- Throughput: 1 beat/cycle sustained with ready_post_i=1. A full word every LANES cycles.
- last_i on lane 0 produces a word with keep_o=0...01.
- last_i on lane LANES-1 is identical to a normal full close, with last_o=1.
- Unused output lanes are always zero. Partial words are never padded with stale data.
- No empty words:
  - valid_pre_i=0 has no effect on state.
  - last_i is ignored unless in_fire.
- cnt wrap: cnt returns to 0 after every close. It never exceeds LANES-1.

Decomposition:
- Shared package hs_pkg:
  - HS_DATA_W=8 constant.
  - Function clog2.
  - Function therm_mask(n) returning n ones from bit 0.
- One sub-module is natural: hs_out_reg, the output register slice.
  - Holds valid, data, keep and last.
  - Load enable = close and in_fire; clear on out_fire.
  - Generates ready_pre_o.
- Packer control and accumulator stay in the top level.

Test Plan:
- Reset, then beats 0x11,0x22,0x33,0x44 with ready_post_i=1 and last_i=0 -> one cycle after 4th beat: data_o=0x44332211, keep_o=4'b1111, last_o=0, valid_post_o high 1 cycle.
- Beats 0xA1,0xA2 with last_i=1 on 0xA2 -> data_o=0x0000A2A1, keep_o=4'b0011, last_o=1.
- Single beat 0x5C with last_i=1 -> data_o=0x0000005C, keep_o=4'b0001, last_o=1.
- Stall: hold ready_post_i=0 after the first word closes -> ready_pre_o=0; data_o stable for 10 cycles.
  - Release ready_post_i -> second word 0x88776655 follows with no lost or duplicated bytes.
- Back-to-back streaming of 64 bytes 0x00..0x3F with ready_post_i=1 -> 16 words (first 0x03020100), ready_pre_o never low, no bubble between words.
- Assert reset_n low after 2 of 4 beats (0xDE,0xAD), then send 0x01..0x04 -> first output word is 0x04030201, keep_o=4'b1111.
  - valid_post_o and all outputs are 0 during reset.
